// File: rtl/div_seq_op.sv
// Sequential unsigned restoring divider: one quotient bit per clock, MSB first,
// start/busy/done handshake. Optional macro DIV_ZERO_FAST_EN short-circuits B==0.
module div_seq_op #(
  parameter int N = 4,
  parameter int M = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [M-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] Y,
  output logic [M-1:0] R,
  output logic         div_zero
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [N-1:0]  dvd;
  logic [M-1:0]  dvs;
  logic [M:0]    p;
  logic [N-1:0]  q;
  logic [CW-1:0] cnt;

  logic [M:0]    p_shift;
  logic [M:0]    p_next;
  logic [N-1:0]  q_next;
  logic          ge;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    p_shift = {p[M-1:0], dvd[N-1]};
    ge      = (p_shift >= {1'b0, dvs});
    p_next  = ge ? (p_shift - {1'b0, dvs}) : p_shift;
    q_next  = {q[N-2:0], ge};
  end

`ifdef DIV_ZERO_FAST_EN
  logic dz_q;
  assign div_zero = dz_q;
`else
  assign div_zero = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      dvd   <= '0;
      dvs   <= '0;
      p     <= '0;
      q     <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      Y     <= '0;
      R     <= '0;
`ifdef DIV_ZERO_FAST_EN
      dz_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            dvd <= A;
            dvs <= B;
            p   <= '0;
            q   <= '0;
            cnt <= '0;
`ifdef DIV_ZERO_FAST_EN
            if (B == '0) begin
              state <= DONE;
              done  <= 1'b1;
              Y     <= '1;
              R     <= '0;
              dz_q  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
`else
            state <= RUN;
            busy  <= 1'b1;
`endif
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          dvd <= dvd << 1;
          p   <= p_next;
          q   <= q_next;
          cnt <= cnt + 1'b1;
          // With B==0 every step subtracts zero, so Y becomes all ones and
          // R keeps the low M dividend bits without any special casing.
          if (cnt == LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            Y     <= q_next;
            R     <= p_next[M-1:0];
`ifdef DIV_ZERO_FAST_EN
            dz_q  <= 1'b0;
`endif
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_op.sv
// Self-checking bench for div_seq_op: directed cases plus shuffled exhaustive
// and random operands checked against an arithmetic reference model.
module tb_div_seq_op;

  localparam int N = 4;
  localparam int M = 2;
`ifdef DIV_ZERO_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  localparam int unsigned ALL1 = (1 << N) - 1;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [N-1:0] A;
  logic [M-1:0] B;
  logic         busy;
  logic         done;
  logic [N-1:0] Y;
  logic [M-1:0] R;
  logic         div_zero;

  int unsigned n_cmp;
  int unsigned n_bad;
  int unsigned prev_y;
  int unsigned prev_r;

  div_seq_op #(.N(N), .M(M)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .Y(Y), .R(R), .div_zero(div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Call at a negedge right after raising start; counts cycles until done.
  task automatic wait_done(output int unsigned lat, output int unsigned bcnt);
    bit seen;
    lat  = 0;
    bcnt = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (done) begin
        seen = 1'b1;
        check("busy_at_done", 32'(busy), 0);
      end else if (busy) begin
        if (bcnt == 0) begin
          check("hold_y", 32'(Y), prev_y);
          check("hold_r", 32'(R), prev_r);
        end
        bcnt++;
      end
    end
    check("done_seen", 32'(seen), 1);
  endtask

  task automatic run_op(input int unsigned a, input int unsigned b);
    int unsigned ey, er, edz, elat, ebusy, lat, bcnt;
    if (b == 0) begin
      ey    = ALL1;
      er    = FAST ? 0 : a % (1 << M);
      edz   = FAST ? 1 : 0;
      elat  = FAST ? 1 : N + 1;
      ebusy = FAST ? 0 : N;
    end else begin
      ey    = a / b;
      er    = a % b;
      edz   = 0;
      elat  = N + 1;
      ebusy = N;
    end
    @(negedge clk);
    A     = a[N-1:0];
    B     = b[M-1:0];
    start = 1'b1;
    wait_done(lat, bcnt);
    check("latency", lat, elat);
    check("busy_cycles", bcnt, ebusy);
    check("quotient", 32'(Y), ey);
    check("remainder", 32'(R), er);
    check("div_zero", 32'(div_zero), edz);
    if (b != 0) begin
      check("invariant", 32'(Y) * b + 32'(R), a);
      check("r_lt_b", 32'(32'(R) < b), 1);
    end
    prev_y = ey;
    prev_r = er;
  endtask

  initial begin
    int unsigned pairs[48];
    int unsigned lat, bcnt, tmp, j, dcnt;

    n_cmp  = 0;
    n_bad  = 0;
    prev_y = 0;
    prev_r = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    A      = '0;
    B      = '0;

    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_y", 32'(Y), 0);
    check("rst_r", 32'(R), 0);
    check("rst_dz", 32'(div_zero), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_busy", 32'(busy), 0);
      check("idle_done", 32'(done), 0);
    end

    run_op(13, 3);
    run_op(15, 1);
    run_op(2, 3);
    run_op(7, 2);
    run_op(9, 0);
    run_op(13, 3);

    for (int unsigned i = 0; i < 48; i++) pairs[i] = ((i / 3) << 8) | (i % 3 + 1);
    for (int unsigned i = 47; i > 0; i--) begin
      j        = $urandom_range(i, 0);
      tmp      = pairs[i];
      pairs[i] = pairs[j];
      pairs[j] = tmp;
    end
    for (int unsigned i = 0; i < 48; i++) run_op(pairs[i] >> 8, pairs[i] & 8'hff);
    for (int i = 0; i < 20; i++) run_op($urandom_range(ALL1, 0), $urandom_range((1 << M) - 1, 0));
    run_op(3, 1);

    // start while busy is ignored; start in the done cycle is accepted
    @(negedge clk);
    A = 4'd7; B = 2'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    A = 4'd15; B = 2'd3; start = 1'b1;
    wait_done(lat, bcnt);
    check("ign_latency", lat, 3);
    check("ign_y", 32'(Y), 3);
    check("ign_r", 32'(R), 1);
    prev_y = 3;
    prev_r = 1;
    A = 4'd9; B = 2'd2; start = 1'b1;
    wait_done(lat, bcnt);
    check("b2b_latency", lat, N + 1);
    check("b2b_busy", bcnt, N);
    check("b2b_y", 32'(Y), 4);
    check("b2b_r", 32'(R), 1);

    // reset mid-run aborts with no done pulse
    @(negedge clk);
    A = 4'd13; B = 2'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_y", 32'(Y), 0);
    check("abort_r", 32'(R), 0);
    check("abort_dz", 32'(div_zero), 0);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    check("abort_no_done", dcnt, 0);
    check("abort_y_hold", 32'(Y), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
